// File: rtl/cmp_pkg.sv
// Shared types for the comparator result checker: FSM states, error record
// layout and the reference model of the 1-bit comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic a;
    logic b;
    logic eq;
    logic lt;
    logic gt;
  } err_rec_t;

  // Expected {eq, lt, gt} for a correct 1-bit magnitude comparator.
  function automatic logic [2:0] exp_flags(input logic a, input logic b);
    return {a ~^ b, ~a & b, a & ~b};
  endfunction

endpackage

// File: rtl/cmp_err_fifo.sv
// Synchronous FIFO for error records with a registered head: valid/dout come
// straight from flops, so a pushed record is visible one cycle after the push.
module cmp_err_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          drop,
  output logic          valid,
  output logic [DW-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          do_push, do_pop;

  // A push into a full FIFO only lands if the head leaves on the same edge.
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop & valid_q;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    dout_d  = valid_d ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
    end
  end

  assign valid = valid_q;
  assign dout  = dout_q;

endmodule

// File: rtl/cmp_result_checker.sv
// Checks a 1-bit comparator's flags over a window of samples and logs mismatches.
// Optional CMP_CHECK_HALT_ON_ERR_EN ends the window at the first mismatch.
module cmp_result_checker
  import cmp_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 16,
  parameter int ERR_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             a_equal_b,
  input  logic             a_less_b,
  input  logic             a_greater_b,
  input  logic             done_ack,
  input  logic             err_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_drop,
  output logic             err_valid,
  output logic [4:0]       err_data
`ifdef CMP_CHECK_HALT_ON_ERR_EN
  ,
  output logic             halted
`endif
);

  localparam int SW = (WINDOW > 1) ? $clog2(WINDOW + 1) : 1;
  localparam logic [SW-1:0] LAST_C = SW'(WINDOW - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] eq_q, eq_d, lt_q, lt_d, gt_q, gt_d, err_q, err_d;
  logic [SW-1:0]    smp_q, smp_d;
  logic             drop_q, drop_d;
  logic             busy_q, done_q;
  logic             halted_q, halted_d;
  logic             accept, mismatch, halt_hit, clear;
  logic             fifo_full, fifo_drop;
  err_rec_t         rec;

  assign accept   = (state_q == RUN) & in_valid;
  assign mismatch = accept & ({a_equal_b, a_less_b, a_greater_b} != exp_flags(a, b));
  assign rec      = {a, b, a_equal_b, a_less_b, a_greater_b};

`ifdef CMP_CHECK_HALT_ON_ERR_EN
  assign halt_hit = mismatch;
  assign halted   = halted_q;
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    err_d    = err_q;
    smp_d    = smp_q;
    drop_d   = drop_q | fifo_drop;
    halted_d = halted_q;
    clear    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        clear   = 1'b1;
      end
      RUN: if (accept) begin
        eq_d  = sat_inc(eq_q, a_equal_b);
        lt_d  = sat_inc(lt_q, a_less_b);
        gt_d  = sat_inc(gt_q, a_greater_b);
        err_d = sat_inc(err_q, mismatch);
        smp_d = smp_q + SW'(1);
        if (halt_hit) begin
          state_d  = DONE;
          halted_d = 1'b1;
        end else if (smp_q == LAST_C) begin
          state_d = DONE;
        end
      end
      DONE: if (done_ack) begin
        state_d = start ? RUN : IDLE;
        clear   = start;
      end
      default: state_d = IDLE;
    endcase
    // A new window starts from a clean slate; the FIFO itself is untouched.
    if (clear) begin
      eq_d     = '0;
      lt_d     = '0;
      gt_d     = '0;
      err_d    = '0;
      smp_d    = '0;
      drop_d   = 1'b0;
      halted_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      eq_q     <= '0;
      lt_q     <= '0;
      gt_q     <= '0;
      err_q    <= '0;
      smp_q    <= '0;
      drop_q   <= 1'b0;
      halted_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      err_q    <= err_d;
      smp_q    <= smp_d;
      drop_q   <= drop_d;
      halted_q <= halted_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  cmp_err_fifo #(
    .DEPTH(ERR_DEPTH),
    .DW   (5)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (mismatch),
    .pop  (err_ready),
    .din  (rec),
    .full (fifo_full),
    .drop (fifo_drop),
    .valid(err_valid),
    .dout (err_data)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign eq_cnt   = eq_q;
  assign lt_cnt   = lt_q;
  assign gt_cnt   = gt_q;
  assign err_cnt  = err_q;
  assign err_drop = drop_q;

endmodule
